// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle between decode, writeback and the register-busy scoreboard.
// Decode/writeback drive through the master modport; the scoreboard is the slave.
interface reg_scoreboard_if #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AWIDTH = 5
);
    logic              iss_valid;
    logic [AWIDTH-1:0] iss_rs1;
    logic              iss_rs1_used;
    logic [AWIDTH-1:0] iss_rs2;
    logic              iss_rs2_used;
    logic [AWIDTH-1:0] iss_rd;
    logic              iss_rd_we;
    logic              iss_ready;
    logic              wb_valid;
    logic [AWIDTH-1:0] wb_rd;
    logic [NREGS-1:0]  pending;
    logic              empty;
    logic              err;

    modport master (
        output iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_rd_we,
        output wb_valid, wb_rd,
        input  iss_ready, pending, empty, err
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_rd_we,
        input  wb_valid, wb_rd,
        output iss_ready, pending, empty, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: per-register outstanding-write counters gating instruction issue.
// x0 is never tracked; underflow on writeback raises a sticky err until reset.
module reg_scoreboard #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned CNTW   = 2,
    parameter bit          BYPASS = 1'b0
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);
    localparam logic [CNTW-1:0] CntMax = '1;

    logic [CNTW-1:0]  cnt_q [NREGS-1:1];
    logic [CNTW-1:0]  cnt_d [NREGS-1:1];
    logic             err_q;
    logic             err_d;
    logic [CNTW-1:0]  rs1_cnt;
    logic [CNTW-1:0]  rs2_cnt;
    logic [CNTW-1:0]  rd_cnt;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             rd_blk;
    logic             ready;
    logic             issue;
    logic [NREGS-1:0] pend;

    // Address decode by search so narrow NREGS never indexes past the array.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (sb.iss_rs1 == AWIDTH'(r)) rs1_cnt = cnt_q[r];
            if (sb.iss_rs2 == AWIDTH'(r)) rs2_cnt = cnt_q[r];
            if (sb.iss_rd == AWIDTH'(r))  rd_cnt  = cnt_q[r];
        end
    end

    always_comb begin
        rs1_haz = sb.iss_rs1_used && (rs1_cnt != '0)
                  && !(BYPASS && (rs1_cnt == CNTW'(1)) && sb.wb_valid && (sb.wb_rd == sb.iss_rs1));
        rs2_haz = sb.iss_rs2_used && (rs2_cnt != '0)
                  && !(BYPASS && (rs2_cnt == CNTW'(1)) && sb.wb_valid && (sb.wb_rd == sb.iss_rs2));
        // No writeback credit here: a full counter blocks even while it is being drained.
        rd_blk  = sb.iss_rd_we && (sb.iss_rd != '0) && (rd_cnt == CntMax);
        ready   = !rs1_haz && !rs2_haz && !rd_blk;
        issue   = sb.iss_valid && ready;
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 1; r < NREGS; r++) begin
            if ((issue && sb.iss_rd_we && (sb.iss_rd == AWIDTH'(r)))
                && !(sb.wb_valid && (sb.wb_rd == AWIDTH'(r)))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if ((sb.wb_valid && (sb.wb_rd == AWIDTH'(r)))
                         && !(issue && sb.iss_rd_we && (sb.iss_rd == AWIDTH'(r)))) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 1; r < NREGS; r++) pend[r] = (cnt_q[r] != '0);
    end

    assign sb.iss_ready = ready;
    assign sb.pending   = pend;
    assign sb.empty     = (pend == '0);
    assign sb.err       = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: BYPASS=0 and BYPASS=1 instances share stimulus and are checked
// against an integer-count reference model via an expected-response queue.
module tb_reg_scoreboard;
    localparam int NREGS  = 32;
    localparam int AWIDTH = 5;
    localparam int MAXCNT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              d_valid, d_u1, d_u2, d_we, d_wbv;
    logic [AWIDTH-1:0] d_rs1, d_rs2, d_rd, d_wbrd;

    reg_scoreboard_if #(.NREGS(NREGS), .AWIDTH(AWIDTH)) sb0 ();
    reg_scoreboard_if #(.NREGS(NREGS), .AWIDTH(AWIDTH)) sb1 ();

    assign sb0.iss_valid = d_valid;  assign sb1.iss_valid = d_valid;
    assign sb0.iss_rs1 = d_rs1;      assign sb1.iss_rs1 = d_rs1;
    assign sb0.iss_rs1_used = d_u1;  assign sb1.iss_rs1_used = d_u1;
    assign sb0.iss_rs2 = d_rs2;      assign sb1.iss_rs2 = d_rs2;
    assign sb0.iss_rs2_used = d_u2;  assign sb1.iss_rs2_used = d_u2;
    assign sb0.iss_rd = d_rd;        assign sb1.iss_rd = d_rd;
    assign sb0.iss_rd_we = d_we;     assign sb1.iss_rd_we = d_we;
    assign sb0.wb_valid = d_wbv;     assign sb1.wb_valid = d_wbv;
    assign sb0.wb_rd = d_wbrd;       assign sb1.wb_rd = d_wbrd;

    reg_scoreboard #(.NREGS(NREGS), .AWIDTH(AWIDTH), .CNTW(2), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sb(sb0)
    );
    reg_scoreboard #(.NREGS(NREGS), .AWIDTH(AWIDTH), .CNTW(2), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sb(sb1)
    );

    typedef struct packed {
        logic [1:0]            ready;
        logic [1:0][NREGS-1:0] pend;
        logic [1:0]            empty;
        logic [1:0]            err;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m[2][NREGS];
    bit   err_m[2];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [NREGS-1:0] act, input logic [NREGS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference hazard rule stated directly on integer counts.
    function automatic bit m_ready(input int k);
        bit h1, h2, blk;
        bit byp;
        byp = (k == 1);
        h1  = d_u1 && d_rs1 != 0 && cnt_m[k][d_rs1] != 0
              && !(byp && cnt_m[k][d_rs1] == 1 && d_wbv && d_wbrd == d_rs1);
        h2  = d_u2 && d_rs2 != 0 && cnt_m[k][d_rs2] != 0
              && !(byp && cnt_m[k][d_rs2] == 1 && d_wbv && d_wbrd == d_rs2);
        blk = d_we && d_rd != 0 && cnt_m[k][d_rd] == MAXCNT;
        return !(h1 || h2 || blk);
    endfunction

    task automatic cycle(input bit r, input bit v, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit we, input bit wbv, input int wbrd);
        exp_t e;
        bit   rdy[2];
        rst = r; d_valid = v; d_rs1 = rs1[AWIDTH-1:0]; d_u1 = u1; d_rs2 = rs2[AWIDTH-1:0];
        d_u2 = u2; d_rd = rd[AWIDTH-1:0]; d_we = we; d_wbv = wbv; d_wbrd = wbrd[AWIDTH-1:0];
        for (int k = 0; k < 2; k++) begin
            rdy[k]     = m_ready(k);
            e.ready[k] = rdy[k];
            e.pend[k]  = '0;
            for (int i = 1; i < NREGS; i++) e.pend[k][i] = (cnt_m[k][i] != 0);
            e.empty[k] = (e.pend[k] == '0);
            e.err[k]   = err_m[k];
        end
        exp_q.push_back(e);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < NREGS; i++) cnt_m[k][i] = 0;
                err_m[k] = 0;
            end else begin
                bit inc, dec;
                inc = v && rdy[k] && we && rd != 0;
                dec = wbv && wbrd != 0;
                if (inc && dec && rd == wbrd) begin
                    // paired update leaves the count alone
                end else begin
                    if (inc) cnt_m[k][rd]++;
                    if (dec) begin
                        if (cnt_m[k][wbrd] == 0) err_m[k] = 1;
                        else cnt_m[k][wbrd]--;
                    end
                end
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready_byp0", NREGS'(sb0.iss_ready), NREGS'(e.ready[0]));
            chk("ready_byp1", NREGS'(sb1.iss_ready), NREGS'(e.ready[1]));
            chk("pending_byp0", sb0.pending, e.pend[0]);
            chk("pending_byp1", sb1.pending, e.pend[1]);
            chk("empty_byp0", NREGS'(sb0.empty), NREGS'(e.empty[0]));
            chk("empty_byp1", NREGS'(sb1.empty), NREGS'(e.empty[1]));
            chk("err_byp0", NREGS'(sb0.err), NREGS'(e.err[0]));
            chk("err_byp1", NREGS'(sb1.err), NREGS'(e.err[1]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; d_valid = 0; d_u1 = 0; d_u2 = 0; d_we = 0; d_wbv = 0;
        d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_wbrd = '0;
        for (int k = 0; k < 2; k++) begin
            err_m[k] = 0;
            for (int i = 0; i < NREGS; i++) cnt_m[k][i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Post-reset state with a hazard-looking instruction: must be ready.
        cycle(0, 1, 5, 1, 6, 1, 7, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RAW stall on x5, released by writeback.
        cycle(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 5, 1, 0, 0, 0, 0, 1, 5);
        cycle(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);

        // x0 is never tracked.
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Saturation on x7: fourth issue held, writeback frees one slot.
        repeat (4) cycle(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 7, 1, 1, 7);
        cycle(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        repeat (3) cycle(0, 0, 7, 1, 0, 0, 0, 0, 1, 7);
        cycle(0, 1, 7, 1, 7, 1, 0, 0, 0, 0);

        // Paired issue and writeback on x9 with count 1.
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 1, 9);
        cycle(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);

        // Underflow on x12 is sticky through later traffic.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
        cycle(0, 1, 0, 0, 0, 0, 12, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);

        // Mid-operation reset with an issue in the same cycle.
        cycle(0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        cycle(0, 1, 4, 1, 3, 1, 0, 0, 0, 0);

        // Randomized traffic on a small register window to keep hazards frequent.
        for (int n = 0; n < 400; n++) begin
            int wr;
            wr = $urandom_range(0, 15);
            if ($urandom_range(0, 9) < 7) begin
                for (int t = 0; t < 4; t++) begin
                    int c;
                    c = $urandom_range(1, 15);
                    if (cnt_m[0][c] != 0) wr = c;
                end
            end
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 1),
                  ($urandom_range(0, 9) < 5), wr);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got=%0d queued expectations required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
